// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit microprocessor datapath: address and page
// field widths, the program-counter reset vector and the action encoding
// used by the PC sequencer's priority encoder.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int PAGE_W = 3;
    localparam int OFFS_W = 5;

    localparam logic [ADDR_W-1:0] PC_RESET = 8'h00;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JMP,
        PC_CALL,
        PC_RET
    } pcAction_e;

endpackage

// File: rtl/pc_return_stack.sv
// ---------------------------------------------------------------------------
// pc_return_stack
// Small LIFO of return addresses for subroutine call/return.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (clears the pointer only)
//   push     in   write pushData on top (ignored when full)
//   pop      in   discard top entry (ignored when empty, wins over push)
//   pushData in   8-bit return address to store
//   top      out  most recently pushed entry (0 while empty)
//   full     out  STACK_DEPTH entries held
//   empty    out  no entries held
// Parameter STACK_DEPTH: number of entries, 2..8.
// ---------------------------------------------------------------------------
module pc_return_stack
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PTR_W-1:0]  sp;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  topIdx;

    // The pointer counts held entries; a pop has priority so a simultaneous
    // request can never both write and release the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (pop && !empty) begin
            sp <= sp - PTR_W'(1);
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end
    end

    // Storage is deliberately left unreset; the pointer alone defines which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop && !full) begin
            mem[sp[IDX_W-1:0]] <= pushData;
        end
    end

    // When sp equals a power-of-two depth its low bits are zero, so the
    // modular decrement still lands on the last slot.
    assign topIdx = sp[IDX_W-1:0] - IDX_W'(1);
    assign top    = empty ? PC_RESET : mem[topIdx];
    assign full   = (sp == PTR_W'(STACK_DEPTH));
    assign empty  = (sp == '0);

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer. Holds the 8-bit PC, exports its page bits to
// the jump-address concatenation logic and applies one action per enabled
// cycle with priority ret > call > jmp > increment.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   advance enable; 0 holds everything
//   jmp         in   load PC from target
//   call        in   push PC+1 and load PC from target
//   ret         in   pop return address into PC
//   target      in   8-bit jump target {page[7:5], offset[4:0]}
//   pc          out  current program counter (registered)
//   page        out  pc[7:5]
//   stack_full  out  return stack holds STACK_DEPTH entries
//   stack_empty out  return stack holds no entries
//   stack_err   out  sticky overflow/underflow, cleared only by rst
// Parameter STACK_DEPTH: return stack entries, 2..8.
// Build option: define PC_STACK_EN to build the return stack; without it
// call acts as jmp, ret acts as increment and the flags are constant 0/1/0.
// ---------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [PAGE_W-1:0] page,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : gBadDepth
        $error("pc_sequencer: STACK_DEPTH must be within 2..8");
    end

    logic [ADDR_W-1:0] pcReg;
    logic [ADDR_W-1:0] pcPlusOne;
    pcAction_e         action;

    assign pcPlusOne = pcReg + ADDR_W'(1);

    // Priority encoder: exactly one action per enabled cycle. Without the
    // return stack a ret still outranks call/jmp but degrades to increment.
    always_comb begin
        action = PC_HOLD;
        if (en) begin
`ifdef PC_STACK_EN
            if (ret)       action = PC_RET;
            else if (call) action = PC_CALL;
            else if (jmp)  action = PC_JMP;
            else           action = PC_INC;
`else
            if (ret)               action = PC_INC;
            else if (call || jmp)  action = PC_JMP;
            else                   action = PC_INC;
`endif
        end
    end

`ifdef PC_STACK_EN
    logic              stackPush;
    logic              stackPop;
    logic [ADDR_W-1:0] stackTop;
    logic              stackFull;
    logic              stackEmpty;
    logic              stackErr;

    assign stackPush = (action == PC_CALL) && !stackFull;
    assign stackPop  = (action == PC_RET)  && !stackEmpty;

    pc_return_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) uStack (
        .clk      (clk),
        .rst      (rst),
        .push     (stackPush),
        .pop      (stackPop),
        .pushData (pcPlusOne),
        .top      (stackTop),
        .full     (stackFull),
        .empty    (stackEmpty)
    );

    // PC register and sticky error; a refused call or ret leaves pc alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg    <= PC_RESET;
            stackErr <= 1'b0;
        end else begin
            case (action)
                PC_INC:  pcReg <= pcPlusOne;
                PC_JMP:  pcReg <= target;
                PC_CALL: begin
                    if (stackFull) stackErr <= 1'b1;
                    else           pcReg    <= target;
                end
                PC_RET: begin
                    if (stackEmpty) stackErr <= 1'b1;
                    else            pcReg    <= stackTop;
                end
                default: pcReg <= pcReg;
            endcase
        end
    end

    assign stack_full  = stackFull;
    assign stack_empty = stackEmpty;
    assign stack_err   = stackErr;
`else
    // Stackless build: only increment and jump ever reach the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg <= PC_RESET;
        end else begin
            case (action)
                PC_INC:  pcReg <= pcPlusOne;
                PC_JMP:  pcReg <= target;
                default: pcReg <= pcReg;
            endcase
        end
    end

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    assign pc   = pcReg;
    assign page = pcReg[ADDR_W-1:ADDR_W-PAGE_W];

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer (STACK_DEPTH=4). Expectations are
// written by hand for each step; the stack-specific section follows the
// PC_STACK_EN build option.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       jmp = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic [2:0] page;
    logic       stackFull;
    logic       stackEmpty;
    logic       stackErr;

    typedef struct {
        logic       rst;
        logic       en;
        logic       jmp;
        logic       call;
        logic       ret;
        logic [7:0] target;
        logic [7:0] expPc;
        logic       expFull;
        logic       expEmpty;
        logic       expErr;
    } vec_t;

    int   compared   = 0;
    int   mismatched = 0;
    int   stepNo     = 0;
    vec_t sbQ[$];
    vec_t tbl[14];

    pc_sequencer #(
        .STACK_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .jmp         (jmp),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .pc          (pc),
        .page        (page),
        .stack_full  (stackFull),
        .stack_empty (stackEmpty),
        .stack_err   (stackErr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic r, input logic e, input logic j,
                                input logic c, input logic rt, input logic [7:0] t,
                                input logic [7:0] p, input logic f, input logic em,
                                input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.jmp = j; v.call = c; v.ret = rt; v.target = t;
        v.expPc = p; v.expFull = f; v.expEmpty = em; v.expErr = er;
        return v;
    endfunction

    // Single comparison with its own FAIL line
    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL step %0d %s: got %h expected %h", stepNo, name, got, want);
        end
    endtask

    // Pop the oldest expectation and compare against the registered outputs
    task automatic checkOutput();
        vec_t e;
        stepNo++;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL step %0d scoreboard: got empty queue expected an entry", stepNo);
            return;
        end
        e = sbQ.pop_front();
        cmp("pc",          pc,                  e.expPc);
        cmp("page",        {5'b0, page},        {5'b0, e.expPc[7:5]});
        cmp("stack_full",  {7'b0, stackFull},   {7'b0, e.expFull});
        cmp("stack_empty", {7'b0, stackEmpty},  {7'b0, e.expEmpty});
        cmp("stack_err",   {7'b0, stackErr},    {7'b0, e.expErr});
    endtask

    // Drive one cycle of inputs on the falling edge, check after the rise
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst    = v.rst;
        en     = v.en;
        jmp    = v.jmp;
        call   = v.call;
        ret    = v.ret;
        target = v.target;
        sbQ.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic driveStep(input logic r, input logic e, input logic j,
                             input logic c, input logic rt, input logic [7:0] t,
                             input logic [7:0] p, input logic f, input logic em,
                             input logic er);
        applyStimulus(mk(r, e, j, c, rt, t, p, f, em, er));
    endtask

    initial begin
        //              rst en jmp call ret target   pc    full empty err
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 1, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h02, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h03, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 8'h25, 8'h25, 0, 1, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 8'h3A, 8'h3A, 0, 1, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 8'h25, 8'h25, 0, 1, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 8'h3A, 8'h25, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 8'h40, 8'h25, 0, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 0, 8'h10, 8'h10, 0, 1, 0);
`ifdef PC_STACK_EN
        tbl[12] = mk(0, 1, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 1, 8'h00, 8'h11, 0, 1, 0);
`else
        tbl[12] = mk(0, 1, 0, 1, 0, 8'h40, 8'h40, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 0, 1, 8'h00, 8'h41, 0, 1, 0);
`endif

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i]);
        end

`ifdef PC_STACK_EN
        $display("[TB] overflow / underflow sequence");
        driveStep(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        driveStep(0, 1, 0, 1, 0, 8'h20, 8'h20, 0, 0, 0);
        driveStep(0, 1, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0);
        driveStep(0, 1, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0);
        driveStep(0, 1, 0, 1, 0, 8'h80, 8'h80, 1, 0, 0);
        driveStep(0, 1, 0, 1, 0, 8'hA0, 8'h80, 1, 0, 1);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h61, 0, 0, 1);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h41, 0, 0, 1);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h21, 0, 0, 1);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h01, 0, 1, 1);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h01, 0, 1, 1);
        driveStep(0, 1, 0, 0, 0, 8'h00, 8'h02, 0, 1, 1);

        $display("[TB] call/ret collision and reset priority");
        driveStep(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        driveStep(0, 1, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0);
        driveStep(0, 1, 0, 1, 1, 8'h50, 8'h01, 0, 1, 0);
        driveStep(0, 1, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0);
        driveStep(1, 1, 0, 1, 0, 8'h70, 8'h00, 0, 1, 0);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1);

        $display("[TB] return-address wrap");
        driveStep(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        driveStep(0, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 0);
        driveStep(0, 1, 0, 1, 0, 8'h12, 8'h12, 0, 0, 0);
        driveStep(0, 1, 1, 0, 1, 8'h77, 8'h00, 0, 1, 0);
`else
        $display("[TB] stackless build sequence");
        driveStep(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        driveStep(0, 1, 0, 1, 0, 8'h80, 8'h80, 0, 1, 0);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h81, 0, 1, 0);
        driveStep(0, 1, 1, 0, 1, 8'h10, 8'h82, 0, 1, 0);
        driveStep(0, 1, 0, 1, 1, 8'h30, 8'h83, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            driveStep(0, 1, 0, 1, 0, 8'h90, 8'h90, 0, 1, 0);
        end
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h91, 0, 1, 0);
        driveStep(0, 1, 0, 0, 1, 8'h00, 8'h92, 0, 1, 0);
        driveStep(1, 1, 0, 1, 0, 8'h55, 8'h00, 0, 1, 0);
`endif

        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d leftover entries expected 0", sbQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
